// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } pwm_cap_state_t;

  localparam int PWM_INTERVAL_DEF = 1200;
  localparam int COUNT_W_DEF      = 16;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus delay register for an asynchronous pin,
// producing one-cycle rise/fall strobes and the synchronized level.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1;
  logic s2;
  logic d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign rise  = s2 & ~d;
  assign fall  = ~s2 & d;
  assign level = s2;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM input in clk cycles,
// flagging a stuck input when an expected edge fails to arrive in time.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int COUNT_W      = COUNT_W_DEF,
  parameter int TIMEOUT      = 4 * PWM_INTERVAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwm_in,
  output logic [COUNT_W-1:0] duty_out,
  output logic [COUNT_W-1:0] period_out,
  output logic               valid,
  output logic               timeout,
  output logic               level
);

  localparam logic [COUNT_W-1:0] CNT_LIMIT = COUNT_W'(TIMEOUT);

  logic               rise;
  logic               fall;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] high_cnt;
  logic               cnt_expired;
  logic               publish;
  logic               enter_stuck;
  logic               latch_high;
  pwm_cap_state_t     state;
  pwm_cap_state_t     state_next;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  assign cnt_expired = (cnt == CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edges are tested before the timeout so a period of exactly TIMEOUT is measured.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rise)             state_next = HIGH;
        else if (cnt_expired) state_next = STUCK;
      end
      HIGH: begin
        if (fall)             state_next = LOW;
        else if (cnt_expired) state_next = STUCK;
      end
      LOW: begin
        if (rise)             state_next = HIGH;
        else if (cnt_expired) state_next = STUCK;
      end
      STUCK: begin
        if (rise)             state_next = HIGH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    publish     = (state == LOW) && rise;
    latch_high  = (state == HIGH) && fall;
    enter_stuck = (state != STUCK) && (state_next == STUCK);
  end

  // The counter restarts at 1 on each rise, so its value at the next edge is the elapsed cycle count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      high_cnt   <= '0;
      duty_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (rise) begin
        cnt <= COUNT_W'(1);
      end else if (!cnt_expired) begin
        cnt <= cnt + COUNT_W'(1);
      end

      if (latch_high) begin
        high_cnt <= cnt;
      end

      valid <= publish | enter_stuck;

      if (publish) begin
        duty_out   <= high_cnt;
        period_out <= cnt;
        timeout    <= 1'b0;
      end else if (enter_stuck) begin
        duty_out   <= '0;
        period_out <= '0;
        timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized PWM waveforms; expected results come from the
// high/low durations the bench chose, compared against every valid pulse.
module tb_pwm_capture;

  localparam int T   = 4800;
  localparam int LAT = 3;

  typedef struct {
    int c;
    int d;
    int p;
    int t;
  } pulse_t;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] duty_out;
  logic [15:0] period_out;
  logic        valid;
  logic        timeout;
  logic        level;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int riseCyc = 0;
  int lastRel = 0;
  int firstRise;
  int hq[$];
  int lq[$];
  pulse_t obsQ[$];
  pulse_t expQ[$];

  pwm_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .timeout    (timeout),
    .level      (level)
  );

  always #5 clk = ~clk;

  // cyc numbers posedges; every valid pulse is logged with its cycle and outputs.
  always @(posedge clk) begin
    pulse_t pk;
    #1;
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      pk.c = cyc;
      pk.d = int'(duty_out);
      pk.p = int'(period_out);
      pk.t = int'(timeout);
      obsQ.push_back(pk);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge: set the pin, then hold it for n cycles.
  task automatic applyStimulus(input logic lv, input int n);
    pwm_in = lv;
    if (lv) riseCyc = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic drivePeriod(input int h, input int l);
    applyStimulus(1'b1, h);
    applyStimulus(1'b0, l);
  endtask

  task automatic expectPulse(input int c, input int d, input int p, input int t);
    pulse_t pk;
    pk.c = c;
    pk.d = d;
    pk.p = p;
    pk.t = t;
    expQ.push_back(pk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " duty"},    int'(duty_out),   0);
    checkOutput({tag, " period"},  int'(period_out), 0);
    checkOutput({tag, " valid"},   int'(valid),      0);
    checkOutput({tag, " timeout"}, int'(timeout),    0);
    checkOutput({tag, " level"},   int'(level),      0);
  endtask

  task automatic doReset(input int n);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
    checkResetOutputs("reset");
    rst_n   = 1'b1;
    lastRel = cyc;
    obsQ.delete();
    expQ.delete();
  endtask

  // Each period's result is published on the rise that starts the next one.
  task automatic runWave(input int finalHigh);
    for (int i = 0; i < hq.size(); i++) begin
      drivePeriod(hq[i], lq[i]);
      if (i > 0) expectPulse(riseCyc + LAT, hq[i-1], hq[i-1] + lq[i-1], 0);
    end
    applyStimulus(1'b1, finalHigh);
    expectPulse(riseCyc + LAT, hq[hq.size()-1], hq[hq.size()-1] + lq[lq.size()-1], 0);
  endtask

  task automatic checkPulses(input string tag);
    int n;
    checkOutput({tag, " count"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d] cycle", tag, i),   obsQ[i].c, expQ[i].c);
      checkOutput($sformatf("%s[%0d] duty", tag, i),    obsQ[i].d, expQ[i].d);
      checkOutput($sformatf("%s[%0d] period", tag, i),  obsQ[i].p, expQ[i].p);
      checkOutput($sformatf("%s[%0d] timeout", tag, i), obsQ[i].t, expQ[i].t);
    end
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);

    $display("[TB] stuck low from reset");
    doReset(4);
    applyStimulus(1'b0, 6000);
    expectPulse(lastRel + T + 1, 0, 0, 1);
    checkPulses("stuck_low");
    checkOutput("stuck_low timeout", int'(timeout),    1);
    checkOutput("stuck_low level",   int'(level),      0);
    checkOutput("stuck_low duty",    int'(duty_out),   0);
    checkOutput("stuck_low period",  int'(period_out), 0);

    $display("[TB] steady 300/900");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{300, 300, 300, 300, 300};
    lq = '{900, 900, 900, 900, 900};
    runWave(10);
    checkPulses("steady");
    checkOutput("steady timeout", int'(timeout),    0);
    checkOutput("steady hold",    int'(period_out), 1200);

    $display("[TB] duty changes");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{600, 1199, 1};
    lq = '{600, 1, 1199};
    runWave(10);
    checkPulses("duty_change");

    $display("[TB] stuck high and recovery");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{300, 300};
    lq = '{900, 900};
    runWave(5000);
    expectPulse(riseCyc + LAT + T, 0, 0, 1);
    checkPulses("stuck_high");
    checkOutput("stuck_high timeout", int'(timeout), 1);
    checkOutput("stuck_high level",   int'(level),   1);
    applyStimulus(1'b0, 900);
    hq = '{300};
    lq = '{900};
    runWave(10);
    checkPulses("recovery");
    checkOutput("recovery timeout", int'(timeout), 0);

    $display("[TB] reset during high phase");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{300};
    lq = '{900};
    runWave(150);
    checkPulses("pre_midreset");
    checkOutput("pre_midreset duty", int'(duty_out), 300);
    rst_n = 1'b0;
    @(negedge clk);
    pwm_in = 1'b0;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 200);
    hq = '{300, 250};
    lq = '{900, 700};
    runWave(10);
    checkPulses("post_midreset");

    $display("[TB] minimum 1/1");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{1, 1};
    lq = '{1, 1};
    runWave(10);
    checkPulses("min_1_1");

    $display("[TB] period equal to timeout");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq = '{2400};
    lq = '{2400};
    runWave(10);
    checkPulses("period_eq_timeout");
    checkOutput("period_eq_timeout flag", int'(timeout), 0);

    $display("[TB] period one past timeout");
    doReset(4);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 2401);
    firstRise = riseCyc;
    applyStimulus(1'b0, 2400);
    applyStimulus(1'b1, 10);
    expectPulse(firstRise + LAT + T, 0, 0, 1);
    checkPulses("period_over_timeout");
    checkOutput("period_over_timeout flag", int'(timeout), 1);

    $display("[TB] random periods");
    doReset(4);
    applyStimulus(1'b0, 10);
    hq.delete();
    lq.delete();
    for (int i = 0; i < 8; i++) begin
      hq.push_back(int'($urandom_range(2400, 1)));
      lq.push_back(int'($urandom_range(2400, 1)));
    end
    runWave(10);
    checkPulses("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
